// File: rtl/freq_m_pkg.sv
// Shared types and defaults for the frequency-measurement datapath.
package freq_m_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} cnt_state_t;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sig_sync_edge.sv
// Brings an asynchronous signal into clk and emits a one-cycle pulse per rising edge.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_rise
);

  // SYNC_STAGES must be at least 2 for metastability protection.
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      prev_p1  <= 1'b0;
      sig_rise <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      // edge detect stage
      prev_p1  <= sync_p0[SYNC_STAGES-1];
      sig_rise <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
    end
  end

endmodule

// File: rtl/freq_cnt_latch.sv
// Counts measured-signal edges between gate pulses and latches each count with a valid/ack handshake.
module freq_cnt_latch
  import freq_m_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             cout_b,
  output logic [CNT_W-1:0] freq_a_out,
  output logic             overflow_out,
  output logic             data_valid,
  output logic             data_lost,
  input  logic             data_ack
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic              sig_rise;
  logic              cout_b_q;
  logic              gate_edge;
  cnt_state_t        state_q;
  cnt_state_t        state_d;
  logic              capture;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic [HOLD_W-1:0] hold_q;

  sig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_in),
    .sig_rise(sig_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) cout_b_q <= 1'b0;
    else       cout_b_q <= cout_b;
  end

  assign gate_edge = cout_b & ~cout_b_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM:  if (gate_edge) state_d = HOLD;
        MEAS: begin
          if (gate_edge) begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end
        HOLD: if (hold_q == '0) state_d = MEAS;
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge counter and hold-off timer; HOLD keeps counting so no edge is lost to the holdoff.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
        ARM: begin
          if (gate_edge) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= HOLD_LOAD;
          end
        end
        MEAS: begin
          if (capture) begin
            count_q <= sig_rise ? CNT_W'(1) : '0;
            ovf_q   <= 1'b0;
            hold_q  <= HOLD_LOAD;
          end else if (sig_rise) begin
            count_q <= sat_inc(count_q);
            ovf_q   <= ovf_q | (count_q == CNT_MAX);
          end
        end
        HOLD: begin
          if (sig_rise) begin
            count_q <= sat_inc(count_q);
            ovf_q   <= ovf_q | (count_q == CNT_MAX);
          end
          if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
        end
        default: count_q <= '0;
      endcase
    end
  end

  // Result register and handshake; survives enable drops, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_a_out   <= '0;
      overflow_out <= 1'b0;
      data_valid   <= 1'b0;
      data_lost    <= 1'b0;
    end else if (capture) begin
      freq_a_out   <= count_q;
      overflow_out <= ovf_q;
      data_valid   <= 1'b1;
      if (data_valid && !data_ack)     data_lost <= 1'b1;
      else if (data_valid && data_ack) data_lost <= 1'b0;
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
      data_lost  <= 1'b0;
    end
  end

endmodule
